// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the sequential RV32M multiply/divide unit:
//   - op_e     : funct3 encodings of the M-extension operations
//   - state_e  : FSM state encodings (IDLE, CALC, DONE)
//   - ITER_CNT : number of one-bit iterations per operation
//   - CNT_W    : width of the iteration counter
//   - helpers  : operand signedness / operation class decode
// -----------------------------------------------------------------------------
package muldiv_pkg;

  localparam int ITER_CNT = 32;
  localparam int CNT_W    = 6;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Divide-class operations all have funct3[2] set.
  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // Remainder operations: REM / REMU.
  function automatic logic op_is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  // rs1 is interpreted as signed for MULH, MULHSU, DIV and REM. MUL is treated
  // as unsigned because the low half of the product does not depend on sign.
  function automatic logic op_rs1_signed(input logic [2:0] op);
    logic s;
    case (op)
      OP_MULH, OP_MULHSU, OP_DIV, OP_REM: s = 1'b1;
      default:                            s = 1'b0;
    endcase
    return s;
  endfunction

  // rs2 is interpreted as signed for MULH, DIV and REM only.
  function automatic logic op_rs2_signed(input logic [2:0] op);
    logic s;
    case (op)
      OP_MULH, OP_DIV, OP_REM: s = 1'b1;
      default:                 s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// -----------------------------------------------------------------------------
// muldiv_if
// Handshake/bus bundle between the core control unit and muldiv_seq.
//   start  : level from cu while the current instruction is M-extension
//   op     : funct3 of the operation
//   rs1    : operand A
//   rs2    : operand B
//   kill   : abort the in-flight operation
//   stall  : freeze PC and register-file write
//   done   : one-cycle pulse, result valid
//   result : operation result
//   busy   : unit not idle
// master = control-unit side, slave = muldiv_seq side.
// -----------------------------------------------------------------------------
interface muldiv_if #(parameter int XLEN = 32);

  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            kill;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output start, op, rs1, rs2, kill,
    input  stall, done, result, busy
  );

  modport slave (
    input  start, op, rs1, rs2, kill,
    output stall, done, result, busy
  );

endinterface

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// One combinational iteration of the unsigned datapath.
//   Multiply (shift-add): {hi,lo} holds the partial product with the multiplier
//     in lo; when lo[0] is set the multiplicand is added into hi, then the
//     whole pair shifts right by one.
//   Divide (restoring): hi is the partial remainder, lo the dividend/quotient;
//     {hi,lo[msb]} is trial-subtracted by the divisor and the quotient bit is
//     shifted into lo[0].
// Ports:
//   i_is_div : 1 = divide step, 0 = multiply step
//   i_hi     : high half of working pair
//   i_lo     : low half of working pair
//   i_opnd   : multiplicand (mul) or divisor (div) magnitude
//   o_hi     : next high half
//   o_lo     : next low half
// -----------------------------------------------------------------------------
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            i_is_div,
  input  logic [XLEN-1:0] i_hi,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_opnd,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shifted;
  logic [XLEN+1:0] w_diff;
  logic            w_ge;

  // Single multiply or divide iteration selected by i_is_div.
  always_comb begin
    w_sum     = {(XLEN+1){1'b0}};
    w_shifted = {(XLEN+1){1'b0}};
    w_diff    = {(XLEN+2){1'b0}};
    w_ge      = 1'b0;
    o_hi      = i_hi;
    o_lo      = i_lo;
    if (i_is_div) begin
      w_shifted = {i_hi, i_lo[XLEN-1]};
      w_diff    = {1'b0, w_shifted} - {2'b00, i_opnd};
      // Remainder is always below the divisor, so the restored value fits XLEN.
      w_ge      = ~w_diff[XLEN+1];
      o_hi      = w_ge ? w_diff[XLEN-1:0] : w_shifted[XLEN-1:0];
      o_lo      = {i_lo[XLEN-2:0], w_ge};
    end else begin
      w_sum = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opnd} : {(XLEN+1){1'b0}});
      o_hi  = w_sum[XLEN:1];
      o_lo  = {w_sum[0], i_lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
// Sequential RV32M multiply/divide unit: one result bit per cycle over 32
// CALC cycles on unsigned magnitudes, with sign fix-up on CALC->DONE.
// Divide-by-zero and signed overflow bypass CALC and complete in one cycle.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : muldiv_if.slave (start/op/rs1/rs2/kill in, stall/done/result/busy out)
// The core ANDs ~stall into its PC-enable and register-file write-enable.
// -----------------------------------------------------------------------------
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_CNT - 1);
  localparam logic [XLEN-1:0]  VAL_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  VAL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  VAL_ZERO = {XLEN{1'b0}};

  state_e            r_state;
  state_e            w_state_nxt;
  op_e               r_op;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_opnd;
  logic [XLEN-1:0]   r_result;
  logic              r_neg_a;
  logic              r_neg_b;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_issue;
  logic              w_step_en;
  logic              w_last;
  logic              w_is_div;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_div_zero;
  logic              w_ovf;
  logic              w_fast;
  logic [XLEN-1:0]   w_fast_res;
  logic [XLEN-1:0]   w_step_hi;
  logic [XLEN-1:0]   w_step_lo;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_fix_res;

  // Issue-cycle operand decode: magnitudes, sign flags and fast-path detection.
  always_comb begin
    w_a_neg    = op_rs1_signed(bus.op) & bus.rs1[XLEN-1];
    w_b_neg    = op_rs2_signed(bus.op) & bus.rs2[XLEN-1];
    w_a_mag    = w_a_neg ? (VAL_ZERO - bus.rs1) : bus.rs1;
    w_b_mag    = w_b_neg ? (VAL_ZERO - bus.rs2) : bus.rs2;
    w_div_zero = (bus.rs2 == VAL_ZERO);
    // Only DIV/REM are both signed-rs1 and divide-class.
    w_ovf      = op_is_div(bus.op) & op_rs1_signed(bus.op) &
                 (bus.rs1 == VAL_MIN) & (bus.rs2 == VAL_ONES);
    w_fast     = op_is_div(bus.op) & (w_div_zero | w_ovf);
    if (w_div_zero) begin
      w_fast_res = op_is_rem(bus.op) ? bus.rs1 : VAL_ONES;
    end else if (w_ovf) begin
      w_fast_res = op_is_rem(bus.op) ? VAL_ZERO : VAL_MIN;
    end else begin
      w_fast_res = VAL_ZERO;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and datapath control; kill has priority over start.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_step_en   = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start && !bus.kill) begin
          w_issue     = 1'b1;
          w_state_nxt = w_fast ? ST_DONE : ST_CALC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (bus.kill) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_step_en = 1'b1;
          if (r_cnt == CNT_LAST) begin
            w_last      = 1'b1;
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_CALC;
          end
        end
      end
      ST_DONE: begin
        // start is ignored here; the next op may issue the following cycle.
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_is_div = op_is_div(r_op);

  muldiv_step #(.XLEN(XLEN)) u_step (
    .i_is_div (w_is_div),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .i_opnd   (r_opnd),
    .o_hi     (w_step_hi),
    .o_lo     (w_step_lo)
  );

  // Sign fix-up on the final iteration output, feeding the result register.
  always_comb begin
    w_prod     = {w_step_hi, w_step_lo};
    w_prod_fix = (r_neg_a ^ r_neg_b) ? ({(2*XLEN){1'b0}} - w_prod) : w_prod;
    case (r_op)
      OP_MUL: begin
        w_fix_res = w_prod_fix[XLEN-1:0];
      end
      OP_MULH, OP_MULHSU, OP_MULHU: begin
        w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
      end
      OP_DIV, OP_DIVU: begin
        // Quotient of magnitudes negated gives truncation toward zero.
        w_fix_res = (r_neg_a ^ r_neg_b) ? (VAL_ZERO - w_step_lo) : w_step_lo;
      end
      OP_REM, OP_REMU: begin
        // Remainder takes the sign of the dividend.
        w_fix_res = r_neg_a ? (VAL_ZERO - w_step_hi) : w_step_hi;
      end
      default: begin
        w_fix_res = VAL_ZERO;
      end
    endcase
  end

  // Operand latch, iteration registers, counter and result register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op     <= OP_MUL;
      r_hi     <= VAL_ZERO;
      r_lo     <= VAL_ZERO;
      r_opnd   <= VAL_ZERO;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_cnt    <= {CNT_W{1'b0}};
      r_result <= VAL_ZERO;
    end else if (w_issue) begin
      r_op    <= op_e'(bus.op);
      r_hi    <= VAL_ZERO;
      // Multiply: multiplier in lo, multiplicand as addend.
      // Divide: dividend in lo, divisor as subtrahend.
      r_lo    <= op_is_div(bus.op) ? w_a_mag : w_b_mag;
      r_opnd  <= op_is_div(bus.op) ? w_b_mag : w_a_mag;
      r_neg_a <= w_a_neg;
      r_neg_b <= w_b_neg;
      r_cnt   <= {CNT_W{1'b0}};
      if (w_fast) begin
        r_result <= w_fast_res;
      end
    end else if (w_step_en) begin
      r_hi  <= w_step_hi;
      r_lo  <= w_step_lo;
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (w_last) begin
        r_result <= w_fix_res;
      end
    end
  end

  // stall covers the issue cycle combinationally so the core freezes at once;
  // gated by reset so it reads 0 while the unit is held in reset.
  assign bus.stall  = reset & ((bus.start & (r_state == ST_IDLE) & ~bus.kill) |
                               (r_state == ST_CALC));
  assign bus.done   = (r_state == ST_DONE) & ~bus.kill;
  assign bus.busy   = (r_state != ST_IDLE);
  assign bus.result = r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_muldiv_seq
// Self-checking bench for muldiv_seq: a table of directed vectors plus
// hand-written sequences for reset, back-to-back issue and kill.
// -----------------------------------------------------------------------------
module tb_muldiv_seq;
  import muldiv_pkg::*;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  muldiv_if #(.XLEN(XLEN)) bus ();

  muldiv_seq #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          fast;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called right after a falling edge; returns at the sample point of the
  // done cycle (or after the cycle budget runs out with got = -1).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int got, output int nstall, output logic st_done,
                        output logic [31:0] res);
    bus.start = 1'b1;
    bus.op    = op;
    bus.rs1   = a;
    bus.rs2   = b;
    got       = -1;
    nstall    = 0;
    st_done   = 1'b0;
    res       = 32'h0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bus.done) begin
        got     = c;
        st_done = bus.stall;
        res     = bus.result;
        break;
      end
      if (bus.stall) nstall++;
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  initial begin
    int          got;
    int          nstall;
    logic        st_done;
    logic [31:0] res;
    int          d1;
    int          d2;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] r_mid;
    logic        seen;

    vecs[0]  = '{"mul_7_m3",     OP_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{"mulhu_ones",   OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{"mulh_ones",    OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[3]  = '{"mulhsu_m1_2",  OP_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{"mulh_min_min", OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0};
    vecs[5]  = '{"mul_shift4",   OP_MUL,    32'h12345678, 32'h00000010, 32'h23456780, 1'b0};
    vecs[6]  = '{"div_ovf",      OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[7]  = '{"rem_ovf",      OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[8]  = '{"divu_by0",     OP_DIVU,   32'd100,      32'h00000000, 32'hFFFFFFFF, 1'b1};
    vecs[9]  = '{"rem_by0",      OP_REM,    32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 1'b1};
    vecs[10] = '{"div_m7_2",     OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0};
    vecs[11] = '{"rem_m7_2",     OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0};
    vecs[12] = '{"divu_9_4",     OP_DIVU,   32'd9,        32'd4,        32'd2,        1'b0};
    vecs[13] = '{"remu_9_4",     OP_REMU,   32'd9,        32'd4,        32'd1,        1'b0};
    vecs[14] = '{"div_7_m2",     OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
    vecs[15] = '{"rem_7_m2",     OP_REM,    32'd7,        32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[16] = '{"divu_min_m1",  OP_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[17] = '{"remu_min_m1",  OP_REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0};

    // Reset state, with start asserted to show stall stays low in reset.
    reset     = 1'b0;
    bus.start = 1'b1;
    bus.kill  = 1'b0;
    bus.op    = OP_DIVU;
    bus.rs1   = 32'd100;
    bus.rs2   = 32'd7;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall",  {63'd0, bus.stall}, 64'd0);
    chk("rst_busy",   {63'd0, bus.busy},  64'd0);
    chk("rst_done",   {63'd0, bus.done},  64'd0);
    chk("rst_result", {32'd0, bus.result}, 64'd0);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Table-driven vectors, each issued the cycle after the previous DONE.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, got, nstall, st_done, res);
      chk({vecs[i].name, "_result"}, {32'd0, res}, {32'd0, vecs[i].exp});
      chk({vecs[i].name, "_latency"}, 64'(got), vecs[i].fast ? 64'd1 : 64'd33);
      chk({vecs[i].name, "_stall_cycles"}, 64'(nstall), vecs[i].fast ? 64'd1 : 64'd33);
      chk({vecs[i].name, "_stall_at_done"}, {63'd0, st_done}, 64'd0);
    end

    // Reset asserted at cycle 10 of a DIVU.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_DIVU;
    bus.rs1   = 32'd100;
    bus.rs2   = 32'd7;
    repeat (10) @(negedge clk);
    #1;
    chk("midrst_busy_before", {63'd0, bus.busy}, 64'd1);
    reset = 1'b0;
    #1;
    chk("midrst_stall",  {63'd0, bus.stall}, 64'd0);
    chk("midrst_busy",   {63'd0, bus.busy},  64'd0);
    chk("midrst_result", {32'd0, bus.result}, 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      if (bus.done) seen = 1'b1;
    end
    chk("midrst_no_done", {63'd0, seen}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op(OP_DIVU, 32'd9, 32'd4, got, nstall, st_done, res);
    chk("postrst_result",  {32'd0, res}, 64'd2);
    chk("postrst_latency", 64'(got), 64'd33);

    // Two MULs with start held: distinct done pulses 34 cycles apart; operand
    // and op changes during the second CALC must not affect its result.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_MUL;
    bus.rs1   = 32'd7;
    bus.rs2   = 32'hFFFFFFFD;
    d1 = -1;
    d2 = -1;
    r1 = 32'h0;
    r2 = 32'h0;
    r_mid = 32'h0;
    for (int c = 0; c < 80; c++) begin
      #1;
      if (bus.done) begin
        if (d1 < 0) begin
          d1 = c;
          r1 = bus.result;
          bus.rs1 = 32'd3;
        end else begin
          d2 = c;
          r2 = bus.result;
          bus.start = 1'b0;
          break;
        end
      end
      if (c == 44) begin
        bus.rs1 = 32'h0000DEAD;
        bus.rs2 = 32'd5;
        bus.op  = OP_DIVU;
      end
      if (c == 50) r_mid = bus.result;
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("b2b_first_done", 64'(d1), 64'd33);
    chk("b2b_gap",        64'(d2 - d1), 64'd34);
    chk("b2b_first_res",  {32'd0, r1}, 64'hFFFFFFEB);
    chk("b2b_held_res",   {32'd0, r_mid}, 64'hFFFFFFEB);
    chk("b2b_second_res", {32'd0, r2}, 64'hFFFFFFF7);

    // Kill at cycle 5 of a DIVU.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_DIVU;
    bus.rs1   = 32'd100;
    bus.rs2   = 32'd3;
    repeat (5) @(negedge clk);
    #1;
    chk("kill_busy_before", {63'd0, bus.busy}, 64'd1);
    bus.kill  = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    bus.kill = 1'b0;
    #1;
    chk("kill_busy_after",  {63'd0, bus.busy},  64'd0);
    chk("kill_stall_after", {63'd0, bus.stall}, 64'd0);
    seen = bus.done;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (bus.done) seen = 1'b1;
    end
    chk("kill_no_done", {63'd0, seen}, 64'd0);

    // Kill in IDLE wins over start.
    @(negedge clk);
    bus.start = 1'b1;
    bus.kill  = 1'b1;
    bus.op    = OP_MUL;
    bus.rs1   = 32'd2;
    bus.rs2   = 32'd2;
    #1;
    chk("killidle_stall", {63'd0, bus.stall}, 64'd0);
    @(negedge clk);
    #1;
    chk("killidle_busy", {63'd0, bus.busy}, 64'd0);
    bus.start = 1'b0;
    bus.kill  = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  level from cu while current instruction is M-extension.
REQ-005 SHALL have port op  input  3  funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (0..7).
REQ-006 SHALL have port rs1  input  XLEN  operand A.
REQ-007 SHALL have port rs2  input  XLEN  operand B.
REQ-008 SHALL have port kill  input  1  abort the in-flight operation.
REQ-009 SHALL have port stall  output  1  freeze PC and register-file write.
REQ-010 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-011 SHALL have port result  output  XLEN  operation result.
REQ-012 SHALL have port busy  output  1  FSM not in IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 SHALL, in IDLE with start=1 and kill=0, latch op, rs1 and rs2, then enter CALC, or enter DONE directly on a special case.
REQ-015 SHALL drive stall = (start & state==IDLE & ~kill) | state==CALC, combinationally, so the core freezes in the issue cycle.
REQ-016 SHALL iterate 32 cycles in CALC: shift-add multiply or restoring divide, one bit per cycle, with a 6-bit counter.
REQ-017 SHALL use unsigned magnitudes internally, with sign fix-up applied on the CALC->DONE transition.
REQ-018 SHALL treat signedness as follows: MULH both operands signed; MULHSU rs1 signed, rs2 unsigned; MULHU/DIVU/REMU unsigned.
REQ-019 SHALL return product[31:0] for MUL and product[63:32] for MULH*, from a 64-bit product.
REQ-020 SHALL give REM the sign of rs1, and SHALL apply DIV truncation toward zero.
REQ-021 SHALL, on divide by zero, fast-path to DONE with quotient 0xFFFFFFFF and remainder rs1.
REQ-022 SHALL, on signed overflow (DIV/REM of 0x80000000 by 0xFFFFFFFF), fast-path with quotient 0x80000000 and remainder 0.
REQ-023 SHALL give normal latency as follows: start seen in cycle 0, done=1 in cycle 33, stall=1 in cycles 0..32 and 0 in cycle 33.
REQ-024 SHALL give fast-path latency as follows: done=1 in cycle 1, stall=1 in cycle 0 only.
REQ-025 SHALL ignore start in DONE, always return DONE->IDLE, and accept a back-to-back start in the following cycle.
REQ-026 SHALL hold result stable from done until the next operation completes.
REQ-027 SHALL, on kill in CALC or DONE, enter IDLE next cycle without a done pulse; kill in IDLE with start=1 SHALL prevent issue (kill wins).
REQ-028 SHALL NOT let changes on rs1/rs2/op during CALC affect the result.

Reset
REQ-029 SHALL, while reset=0, force state=IDLE, counter=0, internal registers=0, result=0, done=0 and busy=0; stall SHALL evaluate to 0.
REQ-030 SHALL abandon an in-flight operation on reset mid-operation, and SHALL accept a new start in the first cycle after reset deasserts.

Structure
REQ-031 SHALL take op encodings, FSM state encodings and ITER_CNT=32 from shared package muldiv_pkg.
REQ-032 SHALL isolate one iteration step (add/shift or trial-subtract/shift) in sub-module muldiv_step, combinational and instantiated once.
REQ-033 SHALL be integrated so that the core ANDs ~stall into PC-enable and register-file write-enable; cu supplies start and op.

Verification
REQ-034 SHALL cover: MUL rs1=7, rs2=0xFFFFFFFD -> result 0xFFFFFFEB, done in cycle 33, stall high for exactly 33 cycles.
REQ-035 SHALL cover: MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-036 SHALL cover: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 with done in cycle 1; REM same operands -> 0.
REQ-037 SHALL cover: DIVU 100/0 -> 0xFFFFFFFF; REM 0xFFFFFFF9 (-7) / 0 -> 0xFFFFFFF9; DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
REQ-038 SHALL cover: reset=0 at cycle 10 of a DIVU -> stall=0, busy=0, no done; new DIVU 9/4 after release -> 2.
REQ-039 SHALL cover: two consecutive MULs held on start -> two distinct done pulses 34 cycles apart; kill at cycle 5 -> no done, busy=0 next cycle.
